// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes, FSM states, opcode legality.
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b100) && (op != 3'b101);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the pointer's port.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = i_ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external 32-bit ALU between two requesters, one operation in flight.
// Accept (IDLE) -> drive ALU (EXEC) -> hold result until the owner takes it (RESP).
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [2:0]         req0_op,
    input  logic [2:0]         req1_op,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [DATA_W-1:0]  resp_result,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [2:0]         alu_ctl,
    input  logic [DATA_W-1:0]  alu_sum,
    input  logic               alu_zout
);

    state_t             r_state;
    logic               r_ptr;
    logic               r_gnt;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [SHAMT_W-1:0] r_shamt;
    logic [2:0]         r_op;
    logic [1:0]         r_resp_valid;
    logic [DATA_W-1:0]  r_resp_result;
    logic               r_resp_zero;
    logic               r_resp_err;
    logic [1:0]         w_gnt;
    logic               w_legal;

    rr_arb2 u_rr_arb2 (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_legal   = is_legal_op(r_op);
    // Grant is only offered from IDLE; masked during reset so nothing is accepted then.
    assign req_ready = (r_state == IDLE && !reset) ? w_gnt : 2'b00;

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_shamt = r_shamt;
    assign alu_ctl   = w_legal ? r_op : ALU_ADD;

    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign resp_err    = r_resp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= 1'b0;
            r_gnt         <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_shamt       <= '0;
            r_op          <= ALU_ADD;
            r_resp_valid  <= 2'b00;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_gnt   <= w_gnt[1];
                        r_a     <= w_gnt[1] ? req1_a     : req0_a;
                        r_b     <= w_gnt[1] ? req1_b     : req0_b;
                        r_shamt <= w_gnt[1] ? req1_shamt : req0_shamt;
                        r_op    <= w_gnt[1] ? req1_op    : req0_op;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_resp_result <= w_legal ? alu_sum  : '0;
                    r_resp_zero   <= w_legal ? alu_zout : 1'b0;
                    r_resp_err    <= !w_legal;
                    r_resp_valid  <= r_gnt ? 2'b10 : 2'b01;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (resp_ready[r_gnt]) begin
                        r_resp_valid <= 2'b00;
                        r_ptr        <= ~r_gnt;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the shared ALU attached.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [2:0]  req0_op, req1_op;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic        resp_err;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_sum;
    logic        alu_zout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_a      (req0_a),
        .req1_a      (req1_a),
        .req0_b      (req0_b),
        .req1_b      (req1_b),
        .req0_shamt  (req0_shamt),
        .req1_shamt  (req1_shamt),
        .req0_op     (req0_op),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_shamt   (alu_shamt),
        .alu_ctl     (alu_ctl),
        .alu_sum     (alu_sum),
        .alu_zout    (alu_zout)
    );

    // External ALU as it sits next to the block in the datapath.
    always_comb begin
        alu_sum = 32'h0;
        case (alu_ctl)
            3'b000: alu_sum = alu_a & alu_b;
            3'b001: alu_sum = alu_a | alu_b;
            3'b010: alu_sum = alu_a + alu_b;
            3'b011: alu_sum = alu_b >> alu_shamt;
            3'b110: alu_sum = alu_a - alu_b;
            3'b111: alu_sum = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_sum = 32'h0;
        endcase
        alu_zout = (alu_sum == 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [2:0] op);
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_shamt = sh; req0_op = op;
        end else begin
            req1_a = a; req1_b = b; req1_shamt = sh; req1_op = op;
        end
    endtask

    // One complete transaction on a single port with cycle-exact checks.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [2:0] op, input logic [2:0] exp_ctl,
                         input logic [31:0] exp_res, input logic exp_z, input logic exp_e);
        logic [1:0] bitp;
        bitp = (p == 0) ? 2'b01 : 2'b10;
        set_port(p, a, b, sh, op);
        req_valid = bitp;
        #1;
        chk("accept_ready", req_ready, bitp);
        tick();
        req_valid = 2'b00;
        #1;
        chk("exec_ready", req_ready, 2'b00);
        chk("exec_valid", resp_valid, 2'b00);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_ctl", alu_ctl, exp_ctl);
        tick();
        chk("resp_valid", resp_valid, bitp);
        chk("resp_result", resp_result, exp_res);
        chk("resp_zero", resp_zero, exp_z);
        chk("resp_err", resp_err, exp_e);
        resp_ready = bitp;
        tick();
        resp_ready = 2'b00;
        #1;
        chk("resp_cleared", resp_valid, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        set_port(0, 32'h0, 32'h0, 5'd0, 3'b010);
        set_port(1, 32'h0, 32'h0, 5'd0, 3'b010);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_result", resp_result, 32'h0);
        chk("rst_zero", resp_zero, 1'b0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_shamt", alu_shamt, 5'd0);
        chk("rst_alu_ctl", alu_ctl, 3'b010);

        // Single-port traffic.
        do_op(0, 32'h12345678, 32'h80000000, 5'd4, 3'b011, 3'b011, 32'h08000000, 1'b0, 1'b0);
        chk("hold_alu_shamt", alu_shamt, 5'd4);
        do_op(1, 32'd5, 32'd5, 5'd0, 3'b110, 3'b110, 32'h0, 1'b1, 1'b0);
        do_op(1, 32'hFFFFFFFF, 32'd1, 5'd0, 3'b111, 3'b111, 32'd1, 1'b0, 1'b0);

        // Both ports saturating, results consumed immediately: grants alternate every 3 cycles.
        set_port(0, 32'd7, 32'd9, 5'd0, 3'b010);
        set_port(1, 32'd100, 32'd23, 5'd0, 3'b010);
        req_valid = 2'b11;
        resp_ready = 2'b11;
        #1;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] owner;
            owner = (((i / 3) % 2) == 0) ? 2'b01 : 2'b10;
            chk("rr_ready", req_ready, (i % 3 == 0) ? owner : 2'b00);
            chk("rr_valid", resp_valid, (i % 3 == 2) ? owner : 2'b00);
            if (i % 3 == 2)
                chk("rr_result", resp_result, (owner == 2'b01) ? 32'd16 : 32'd123);
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;

        // Backpressure on port 0 while port 1 waits.
        set_port(0, 32'd1, 32'd2, 5'd0, 3'b010);
        req_valid = 2'b01;
        #1;
        chk("bp_accept0", req_ready, 2'b01);
        tick();
        set_port(1, 32'd7, 32'd9, 5'd0, 3'b010);
        req_valid = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 2'b01);
            chk("bp_result", resp_result, 32'd3);
            chk("bp_ready", req_ready, 2'b00);
            resp_ready = 2'b10;
            tick();
            resp_ready = 2'b00;
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        #1;
        chk("bp_grant1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        chk("bp_resp1", resp_valid, 2'b10);
        chk("bp_result1", resp_result, 32'd16);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;

        // Illegal opcode, then a legal AND.
        do_op(0, 32'h1234, 32'h5678, 5'd0, 3'b100, 3'b010, 32'h0, 1'b0, 1'b1);
        do_op(0, 32'h0000F0F0, 32'h00000FF0, 5'd0, 3'b000, 3'b000, 32'h000000F0, 1'b0, 1'b0);

        // Reset while in EXEC: operation vanishes and pointer (now 1) goes back to 0.
        set_port(0, 32'd11, 32'd22, 5'd0, 3'b010);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstx_valid", resp_valid, 2'b00);
            chk("rstx_result", resp_result, 32'h0);
            tick();
        end
        set_port(1, 32'd3, 32'd4, 5'd0, 3'b010);
        req_valid = 2'b11;
        #1;
        chk("rstx_grant0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        chk("rstx_resp0", resp_valid, 2'b01);
        chk("rstx_result0", resp_result, 32'd33);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 32-bit combinational ALU between two requesters: the main datapath (port 0) and the branch/compare unit (port 1). The block accepts one operation at a time through a valid/ready request handshake and arbitrates round-robin between the ports. It drives the shared ALU from registered operands, captures the ALU's sum and zero outputs, and returns them through a valid/ready response handshake. It sits between the requesters and the ALU instance in the datapath top level.

Parameters:
DATA_W, 32, operand/result width; must match the ALU width.
SHAMT_W, 5, shift-amount width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: operation from requester i accepted this cycle (one-hot or zero)
req0_a, req1_a  input  DATA_W  operand A per requester
req0_b, req1_b  input  DATA_W  operand B per requester
req0_shamt, req1_shamt  input  SHAMT_W  shift amount per requester
req0_op, req1_op  input  3  ALU control code per requester
resp_valid  output  2  bit i: result for requester i available
resp_ready  input  2  bit i: requester i consumes the result
resp_result  output  DATA_W  captured ALU sum
resp_zero  output  1  captured ALU zero flag
resp_err  output  1  operation code was illegal
alu_a, alu_b  output  DATA_W  to shared ALU
alu_shamt  output  SHAMT_W  to shared ALU
alu_ctl  output  3  to shared ALU control line
alu_sum  input  DATA_W  from shared ALU
alu_zout  input  1  from shared ALU

Behaviour:
- Legal ALU codes: 000 AND, 001 OR, 010 ADD, 011 SRL (B >> shamt), 110 SUB, 111 SLT (signed, result 1/0). Codes 100 and 101 are illegal.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=0, resp_valid=0, resp_result=0, resp_zero=0, resp_err=0, alu_a=0, alu_b=0, alu_shamt=0, alu_ctl=010, priority pointer=0 (requester 0 favoured).
- IDLE: if any req_valid bit is set, grant exactly one requester. If only one is requesting, it is granted. If both are requesting, the pointer's port is granted. In the grant cycle, req_ready[g]=1 combinationally. On that edge: latch a, b, shamt and op into operand registers, record g, then go to EXEC. req_ready is 0 in every other state.
- EXEC (exactly 1 cycle): alu_* outputs are driven from the operand registers. On the edge: resp_result<=alu_sum, resp_zero<=alu_zout, resp_err<=0; then go to RESP.
- Illegal op in EXEC: alu_ctl is driven as 010 and is don't-care. Capture resp_result=0, resp_zero=0, resp_err=1.
- RESP: resp_valid[g]=1; the response fields stay stable. When resp_ready[g]=1 on an edge: go to IDLE, clear resp_valid, set the pointer to the other port (1-g).
- No bypass: a new request is accepted only in IDLE. Acceptance-to-resp_valid latency is 2 cycles. Minimum initiation interval is 3 cycles.
- resp_ready on a non-granted port is ignored.
- Between operations, alu_* outputs hold the last operand register values.
- Reset asserted in any state: the transaction in flight is dropped, no response is issued, the next cycle is IDLE with reset values, and the pointer returns to 0.
- Requesters must hold their request stable while req_valid=1 and req_ready=0. The block does not check this.

Decomposition:
- Shared package holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SRL, ALU_SUB, ALU_SLT).
  - The FSM state encoding (IDLE, EXEC, RESP).
  - An is_legal_op function.
- Natural sub-module: rr_arb2, a 2-way round-robin grant generator (inputs req[1:0] and pointer; output one-hot grant).
- The ALU stays external and is instantiated alongside this block at the datapath top level.

Test Plan:
- Port 0 only: op 011, b=0x80000000, shamt=4 -> req_ready[0] in the accept cycle, resp_valid[0] 2 cycles later, result=0x08000000, zero=0, err=0.
- Port 1 only: SUB, a=5, b=5 -> result=0x00000000, zero=1. Then SLT a=0xFFFFFFFF, b=1 -> result=1, zero=0.
- Both ports hold valid continuously, resp_ready tied high, pointer 0 -> grants alternate 0,1,0,1; each port is served every 6 cycles with correct ADD results (e.g., 7+9=16).
- Backpressure: hold resp_ready[0]=0 for 5 cycles while port 1 requests -> result held stable, req_ready stays 0. Once resp_ready[0]=1, port 1 is granted in the next IDLE.
- Illegal op 100 from port 0 -> resp_err=1, result=0, zero=0. The following legal AND 0xF0F0 & 0x0FF0 -> 0x00F0, err=0.
- Assert reset during EXEC -> no resp_valid ever appears for that operation. After reset, simultaneous requests grant port 0 first.
